sdram_device_model: RTL and testbench

SDRAM_DEVICE_MODEL -- requirements
Module: sdram_device_model

---
 rtl/sdram_pkg.sv | 37 +++
 rtl/sdram_rd_pipe.sv | 34 +++
 rtl/sdram_device_model.sv | 127 ++++++++++++
 tb/tb_sdram_device_model.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM device model: command encodings, bank
// states, protocol-violation codes and column geometry.
package sdram_pkg;

  localparam int COL_W  = 8;
  localparam int ROW_W  = 12;
  localparam int DATA_W = 16;
  localparam int MAX_CL = 3;

  typedef enum logic [2:0] {
    CMD_LMR = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_BST = 3'b110,
    CMD_NOP = 3'b111
  } cmd_e;

  typedef enum logic {
    BANK_IDLE,
    BANK_ACTIVE
  } bank_state_e;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_RW_IDLE = 3'd1;
  localparam logic [2:0] ERR_ACT_ACT = 3'd2;
  localparam logic [2:0] ERR_ACT_CMD = 3'd3;
  localparam logic [2:0] ERR_REFRESH = 3'd4;
  localparam logic [2:0] ERR_MODE    = 3'd5;

  function automatic logic isValidCl(input logic [2:0] cl);
    return (cl == 3'd2) || (cl == 3'd3);
  endfunction

endpackage

// File: rtl/sdram_rd_pipe.sv
// Read-latency shift register: valid and data march one stage per clock and
// the output is taken from a runtime-selected stage.
module sdram_rd_pipe #(
  parameter int DEPTH = 3,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_i,
  input  logic [W-1:0]             data_i,
  input  logic [$clog2(DEPTH)-1:0] tap_i,
  output logic                     valid_o,
  output logic [W-1:0]             data_o
);

  logic [DEPTH-1:0] valid_q;
  logic [W-1:0]     data_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      valid_q   <= {valid_q[DEPTH-2:0], valid_i};
      data_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) data_q[i] <= data_q[i-1];
    end
  end

  // Data is forced to zero outside its single valid cycle.
  assign valid_o = valid_q[tap_i];
  assign data_o  = valid_o ? data_q[tap_i] : '0;

endmodule

// File: rtl/sdram_device_model.sv
// Single-bank SDRAM device model: decodes pin commands, stores write data,
// returns read data after the programmed CAS latency and flags protocol errors.
module sdram_device_model
  import sdram_pkg::*;
#(
  parameter int MEM_AW     = 12,
  parameter int T_RI_MAX   = 64,
  parameter int CL_DEFAULT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ras_n,
  input  logic              cas_n,
  input  logic              we_n,
  input  logic [ROW_W-1:0]  addr,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              data_oe,
  output logic              error,
  output logic [2:0]        err_code
);

  localparam int RCNT_W = $clog2(T_RI_MAX + 2);
  localparam logic [RCNT_W-1:0] REF_LIMIT = RCNT_W'(T_RI_MAX);
  localparam logic [RCNT_W-1:0] REF_SAT   = RCNT_W'(T_RI_MAX + 1);
  localparam logic [RCNT_W-1:0] REF_ONE   = RCNT_W'(1);

  cmd_e                  cmd;
  bank_state_e           state_q, state_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [2:0]            casLat_q, casLat_d;
  logic [RCNT_W-1:0]     refCnt_q, refCnt_d;
  logic                  error_q, error_d;
  logic [2:0]            errCode_q, errCode_d;
  logic [2:0]            viol;
  logic                  rdEn, wrEn;
  logic [ROW_W+COL_W-1:0] fullIdx;
  logic [MEM_AW-1:0]     memIdx;
  logic                  unusedIdx;
  logic [DATA_W-1:0]     mem [2**MEM_AW];

  assign cmd       = cmd_e'({ras_n, cas_n, we_n});
  assign fullIdx   = {row_q, addr[COL_W-1:0]};
  assign memIdx    = fullIdx[MEM_AW-1:0];
  assign unusedIdx = ^fullIdx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BANK_IDLE;
      row_q     <= '0;
      casLat_q  <= 3'(CL_DEFAULT);
      refCnt_q  <= '0;
      error_q   <= 1'b0;
      errCode_q <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      casLat_q  <= casLat_d;
      refCnt_q  <= refCnt_d;
      error_q   <= error_d;
      errCode_q <= errCode_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    casLat_d  = casLat_q;
    error_d   = error_q;
    errCode_d = errCode_q;
    viol      = ERR_NONE;
    rdEn      = 1'b0;
    wrEn      = 1'b0;
    if (cmd == CMD_REF)          refCnt_d = '0;
    else if (refCnt_q == REF_SAT) refCnt_d = refCnt_q;
    else                          refCnt_d = refCnt_q + REF_ONE;

    unique case (cmd)
      CMD_ACT: begin
        if (state_q == BANK_IDLE) begin
          state_d = BANK_ACTIVE;
          row_d   = addr;
        end else begin
          viol = ERR_ACT_ACT;
        end
      end
      CMD_RD:  if (state_q == BANK_ACTIVE) rdEn = 1'b1; else viol = ERR_RW_IDLE;
      CMD_WR:  if (state_q == BANK_ACTIVE) wrEn = 1'b1; else viol = ERR_RW_IDLE;
      CMD_PRE: state_d = BANK_IDLE;
      CMD_REF: if (state_q == BANK_ACTIVE) viol = ERR_ACT_CMD;
      CMD_LMR: begin
        if (state_q == BANK_ACTIVE)    viol     = ERR_ACT_CMD;
        else if (isValidCl(addr[6:4])) casLat_d = addr[6:4];
        else                           viol     = ERR_MODE;
      end
      default: ;
    endcase

    // A command violation outranks an overdue refresh in the same cycle.
    if (viol == ERR_NONE && cmd != CMD_REF && refCnt_q >= REF_LIMIT) viol = ERR_REFRESH;
    if (viol != ERR_NONE && !error_q) begin
      error_d   = 1'b1;
      errCode_d = viol;
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn) mem[memIdx] <= data_i;
  end

  sdram_rd_pipe #(
    .DEPTH (MAX_CL),
    .W     (DATA_W)
  ) uRdPipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (rdEn),
    .data_i  (mem[memIdx]),
    .tap_i   ($clog2(MAX_CL)'(casLat_q - 3'd1)),
    .valid_o (data_oe),
    .data_o  (data_o)
  );

  assign error    = error_q;
  assign err_code = errCode_q;

endmodule

// File: tb/tb_sdram_device_model.sv
// Self-checking bench for sdram_device_model: directed scenarios plus a
// randomized command stream compared against a command-level reference model.
module tb_sdram_device_model;

  localparam int MEM_AW     = 12;
  localparam int T_RI_MAX   = 64;
  localparam int CL_DEFAULT = 2;

  localparam logic [2:0] C_LMR = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100, C_RD  = 3'b101, C_NOP = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic [11:0] addr = '0;
  logic [15:0] data_i = '0;
  logic [15:0] data_o;
  logic        data_oe;
  logic        error;
  logic [2:0]  err_code;

  sdram_device_model #(
    .MEM_AW     (MEM_AW),
    .T_RI_MAX   (T_RI_MAX),
    .CL_DEFAULT (CL_DEFAULT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ras_n    (ras_n),
    .cas_n    (cas_n),
    .we_n     (we_n),
    .addr     (addr),
    .data_i   (data_i),
    .data_o   (data_o),
    .data_oe  (data_oe),
    .error    (error),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  int total = 0;
  int bad   = 0;

  // A returned word and the rising edge at which it is presented to the controller.
  typedef struct {
    int          at;
    logic [15:0] d;
  } ret_t;

  ret_t        expQ[$];
  ret_t        obsQ[$];
  logic [15:0] mmem [int];
  bit          mActive, mErr;
  int          mRow, mCl, mCode, mSince;

  function automatic int memIdx(input int row, input int col);
    return (row * 256 + col) % (1 << MEM_AW);
  endfunction

  task automatic resetModel();
    mActive = 0; mRow = 0; mCl = CL_DEFAULT; mErr = 0; mCode = 0; mSince = 0;
    expQ.delete();
    obsQ.delete();
  endtask

  // Applies one command to the reference model at the edge that samples it.
  task automatic modelCmd(input logic [2:0] c, input logic [11:0] a, input logic [15:0] d, input int at);
    int v;
    int m;
    v = 0;
    case (c)
      C_ACT: if (mActive) v = 2; else begin mActive = 1; mRow = int'(a); end
      C_RD:  if (!mActive) v = 1; else expQ.push_back('{at + mCl, mmem[memIdx(mRow, int'(a[7:0]))]});
      C_WR:  if (!mActive) v = 1; else mmem[memIdx(mRow, int'(a[7:0]))] = d;
      C_PRE: mActive = 0;
      C_REF: if (mActive) v = 3;
      C_LMR: begin
        m = int'(a[6:4]);
        if (mActive) v = 3;
        else if (m == 2 || m == 3) mCl = m;
        else v = 5;
      end
      default: ;
    endcase
    mSince = (c == C_REF) ? 0 : mSince + 1;
    if (v == 0 && mSince > T_RI_MAX) v = 4;
    if (v != 0 && !mErr) begin mErr = 1; mCode = v; end
  endtask

  // Entered just after a falling edge: drive, let one rising edge sample, observe.
  task automatic tick(input logic [2:0] c, input logic [11:0] a, input logic [15:0] d);
    {ras_n, cas_n, we_n} = c;
    addr   = a;
    data_i = d;
    modelCmd(c, a, d, edges + 1);
    @(negedge clk);
    if (data_oe !== 1'b0) obsQ.push_back('{edges + 1, data_o});
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) tick(C_NOP, 12'h000, 16'h0000);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    {ras_n, cas_n, we_n} = C_NOP;
    addr = '0;
    data_i = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    resetModel();
  endtask

  task automatic test_reset();
    doReset();
    tick(C_RD, 12'h005, 16'h0000);
    total++; if (error !== 1'b1) begin bad++; $display("[TB] FAIL rst_pre_error: got %b want 1", error); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (error !== 1'b0) begin bad++; $display("[TB] FAIL rst_error: got %b want 0", error); end
    total++; if (err_code !== 3'd0) begin bad++; $display("[TB] FAIL rst_code: got %0d want 0", err_code); end
    total++; if (data_oe !== 1'b0) begin bad++; $display("[TB] FAIL rst_oe: got %b want 0", data_oe); end
    total++; if (data_o !== 16'h0000) begin bad++; $display("[TB] FAIL rst_data: got %h want 0000", data_o); end
    doReset();
  endtask

  task automatic test_write_read_32();
    int rdEdge [32];
    doReset();
    tick(C_ACT, 12'h000, 16'h0000);
    for (int i = 0; i < 32; i++) tick(C_WR, 12'(i), 16'(i));
    tick(C_PRE, 12'h000, 16'h0000);
    tick(C_REF, 12'h000, 16'h0000);
    tick(C_ACT, 12'h000, 16'h0000);
    for (int i = 0; i < 32; i++) begin
      tick(C_RD, 12'(i), 16'h0000);
      rdEdge[i] = edges;
    end
    nops(4);
    total++; if (obsQ.size() != 32) begin bad++; $display("[TB] FAIL wr32_count: got %0d want 32", obsQ.size()); end
    for (int i = 0; i < 32 && i < obsQ.size(); i++) begin
      total++;
      if (obsQ[i].d !== 16'(i) || obsQ[i].at != rdEdge[i] + 2) begin
        bad++;
        $display("[TB] FAIL wr32_data[%0d]: got %h@%0d want %h@%0d", i, obsQ[i].d, obsQ[i].at, 16'(i), rdEdge[i] + 2);
      end
    end
    total++; if (error !== 1'b0) begin bad++; $display("[TB] FAIL wr32_error: got %b want 0", error); end
  endtask

  task automatic test_cl3();
    int rdEdge;
    doReset();
    tick(C_LMR, 12'h030, 16'h0000);
    tick(C_ACT, 12'h001, 16'h0000);
    tick(C_WR, 12'h020, 16'hBEEF);
    tick(C_RD, 12'h020, 16'h0000);
    rdEdge = edges;
    nops(5);
    total++; if (obsQ.size() != 1) begin bad++; $display("[TB] FAIL cl3_count: got %0d want 1", obsQ.size()); end
    if (obsQ.size() > 0) begin
      total++;
      if (obsQ[0].d !== 16'hBEEF || obsQ[0].at != rdEdge + 3) begin
        bad++;
        $display("[TB] FAIL cl3_data: got %h@%0d want beef@%0d", obsQ[0].d, obsQ[0].at, rdEdge + 3);
      end
    end
    total++; if (error !== 1'b0) begin bad++; $display("[TB] FAIL cl3_error: got %b want 0", error); end
  endtask

  task automatic test_idle_read();
    doReset();
    tick(C_RD, 12'h003, 16'h0000);
    nops(4);
    total++; if (error !== 1'b1) begin bad++; $display("[TB] FAIL idle_rd_error: got %b want 1", error); end
    total++; if (err_code !== 3'd1) begin bad++; $display("[TB] FAIL idle_rd_code: got %0d want 1", err_code); end
    total++; if (obsQ.size() != 0) begin bad++; $display("[TB] FAIL idle_rd_oe: got %0d pulses want 0", obsQ.size()); end
    tick(C_ACT, 12'h000, 16'h0000);
    tick(C_ACT, 12'h001, 16'h0000);
    total++; if (err_code !== 3'd1) begin bad++; $display("[TB] FAIL act_act_sticky: got %0d want 1", err_code); end
    total++; if (err_code !== 3'(mCode)) begin bad++; $display("[TB] FAIL act_act_model: got %0d want %0d", err_code, mCode); end
  endtask

  task automatic test_bad_mode();
    doReset();
    tick(C_LMR, 12'h010, 16'h0000);
    total++; if (error !== 1'b1 || err_code !== 3'd5) begin bad++; $display("[TB] FAIL bad_mode: got %b/%0d want 1/5", error, err_code); end
  endtask

  task automatic test_refresh();
    doReset();
    nops(T_RI_MAX);
    total++; if (error !== 1'b0) begin bad++; $display("[TB] FAIL ref_limit_ok: got %b want 0", error); end
    nops(1);
    total++; if (error !== 1'b1 || err_code !== 3'd4) begin bad++; $display("[TB] FAIL ref_overdue: got %b/%0d want 1/4", error, err_code); end
    doReset();
    for (int i = 0; i < 200; i++) begin
      if (i % 32 == 31) tick(C_REF, 12'h000, 16'h0000);
      else tick(C_NOP, 12'h000, 16'h0000);
    end
    total++; if (error !== 1'b0) begin bad++; $display("[TB] FAIL ref_periodic: got %b want 0", error); end
    // Overdue refresh coinciding with an illegal ACTIVE must report the command.
    doReset();
    tick(C_ACT, 12'h000, 16'h0000);
    nops(T_RI_MAX - 1);
    total++; if (error !== 1'b0) begin bad++; $display("[TB] FAIL ref_prio_pre: got %b want 0", error); end
    tick(C_ACT, 12'h001, 16'h0000);
    total++; if (err_code !== 3'd2) begin bad++; $display("[TB] FAIL ref_prio_code: got %0d want 2", err_code); end
  endtask

  task automatic test_back_to_back();
    int e1, e2;
    logic [15:0] dA, dB;
    dA = 16'($urandom);
    dB = ~dA;
    doReset();
    tick(C_ACT, 12'h003, 16'h0000);
    tick(C_WR, 12'h007, dA);
    tick(C_RD, 12'h007, 16'h0000);
    e1 = edges;
    tick(C_WR, 12'h007, dB);
    tick(C_RD, 12'h007, 16'h0000);
    e2 = edges;
    nops(4);
    total++; if (obsQ.size() != 2) begin bad++; $display("[TB] FAIL b2b_count: got %0d want 2", obsQ.size()); end
    if (obsQ.size() == 2) begin
      total++; if (obsQ[0].d !== dA || obsQ[0].at != e1 + 2) begin bad++; $display("[TB] FAIL b2b_first: got %h@%0d want %h@%0d", obsQ[0].d, obsQ[0].at, dA, e1 + 2); end
      total++; if (obsQ[1].d !== dB || obsQ[1].at != e2 + 2) begin bad++; $display("[TB] FAIL b2b_second: got %h@%0d want %h@%0d", obsQ[1].d, obsQ[1].at, dB, e2 + 2); end
    end
  endtask

  task automatic test_reset_inflight();
    logic [15:0] dW;
    dW = 16'($urandom);
    doReset();
    tick(C_ACT, 12'h002, 16'h0000);
    tick(C_WR, 12'h009, dW);
    tick(C_RD, 12'h009, 16'h0000);
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if (data_oe !== 1'b0) begin bad++; $display("[TB] FAIL inflight_in_reset[%0d]: got %b want 0", i, data_oe); end
    end
    rst_n = 1'b1;
    resetModel();
    nops(4);
    total++; if (obsQ.size() != 0) begin bad++; $display("[TB] FAIL inflight_after: got %0d pulses want 0", obsQ.size()); end
    tick(C_ACT, 12'h002, 16'h0000);
    tick(C_RD, 12'h009, 16'h0000);
    nops(3);
    total++; if (obsQ.size() != 1 || obsQ[0].d !== dW) begin bad++; $display("[TB] FAIL inflight_mem: got %0d pulses want 1 of %h", obsQ.size(), dW); end
  endtask

  task automatic test_random();
    int col, r;
    doReset();
    for (int n = 0; n < 300; n++) begin
      if (n % 24 == 0) begin
        tick(C_PRE, 12'h000, 16'h0000);
        tick(C_REF, 12'h000, 16'h0000);
      end else if (!mActive) begin
        tick(C_ACT, 12'($urandom_range(0, 15)), 16'h0000);
      end else begin
        r   = $urandom_range(0, 9);
        col = $urandom_range(0, 15);
        if (r == 0) tick(C_PRE, 12'h000, 16'h0000);
        else if (r == 9) tick(C_NOP, 12'h000, 16'h0000);
        else if (r >= 5 && mmem.exists(memIdx(mRow, col))) tick(C_RD, 12'(col), 16'h0000);
        else tick(C_WR, 12'(col), 16'($urandom));
      end
    end
    nops(4);
    total++; if (obsQ.size() != expQ.size()) begin bad++; $display("[TB] FAIL rnd_count: got %0d want %0d", obsQ.size(), expQ.size()); end
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      total++;
      if (obsQ[i].d !== expQ[i].d || obsQ[i].at != expQ[i].at) begin
        bad++;
        $display("[TB] FAIL rnd_data[%0d]: got %h@%0d want %h@%0d", i, obsQ[i].d, obsQ[i].at, expQ[i].d, expQ[i].at);
      end
    end
    total++; if (error !== 1'(mErr)) begin bad++; $display("[TB] FAIL rnd_error: got %b want %b", error, mErr); end
  endtask

  initial begin
    resetModel();
    test_reset();
    test_write_read_32();
    test_cl3();
    test_idle_read();
    test_bad_mode();
    test_refresh();
    test_back_to_back();
    test_reset_inflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
